// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light command sequencer: FSM encoding,
// default widths and the layout of the 3-bit table index {light[1:0], color}.
package traffic_pkg;

  localparam int TIME_W_DEF = 5;
  localparam int N_ENTRY    = 8;
  localparam int IDX_W      = 3;
  localparam int CNT_W      = 4;

  // Index field positions: light = idx[2:1], color = idx[0]
  localparam int LIGHT_HI  = 2;
  localparam int LIGHT_LO  = 1;
  localparam int COLOR_BIT = 0;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SCAN    = 3'd1,
    S_SETUP   = 3'd2,
    S_SEND    = 3'd3,
    S_GO_WAIT = 3'd4,
    S_GO      = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  function automatic logic [1:0] light_of(input logic [IDX_W-1:0] idx);
    return idx[LIGHT_HI:LIGHT_LO];
  endfunction

  function automatic logic color_of(input logic [IDX_W-1:0] idx);
    return idx[COLOR_BIT];
  endfunction

endpackage

// File: rtl/traffic_cfg_tbl.sv
// 8 x TIME_W duration table (4 lights x 2 colours). Asynchronous read,
// synchronous write that is refused while a sequence is replaying.
module traffic_cfg_tbl
  import traffic_pkg::*;
#(
  parameter int TIME_W   = TIME_W_DEF,
  parameter int DEF_TIME = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_busy,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [TIME_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [TIME_W-1:0] o_rdata
);

  logic [TIME_W-1:0] r_mem [N_ENTRY];

  // Table storage: reset to the default duration, writes only when idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_ENTRY; i++) r_mem[i] <= TIME_W'(DEF_TIME);
    end else if (i_we && !i_busy) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/traffic_cfg_seq.sv
// Traffic-light command initiator: replays the duration table as paced
// inst_send commands followed by one inst_go pulse.
// Optional build macro TRAFFIC_CFG_ABORT_EN adds an 'abort' input that
// returns the FSM to IDLE from any active state.
// Handshake: there is no back-pressure; inst_send/inst_go are one-cycle
// strobes and the field outputs are stable for HOLD cycles before each one.
module traffic_cfg_seq
  import traffic_pkg::*;
#(
  parameter int TIME_W   = TIME_W_DEF,
  parameter int HOLD     = 2,
  parameter int DEF_TIME = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        start_mask,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_addr,
  input  logic [TIME_W-1:0] cfg_time,
`ifdef TRAFFIC_CFG_ABORT_EN
  input  logic              abort,
`endif
  output logic              inst_send,
  output logic              inst_go,
  output logic [1:0]        traffic_sel,
  output logic              color_sel,
  output logic              start_color,
  output logic [TIME_W-1:0] input_time,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [3:0]        r_mask;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_traffic_sel;
  logic              r_color_sel;
  logic              r_start_color;
  logic [TIME_W-1:0] r_input_time;
  logic [TIME_W-1:0] w_rd_data;
  logic              w_abort;
  logic              w_last;
  logic              w_skip;
  logic              w_cnt_done;
  logic              w_busy;

`ifdef TRAFFIC_CFG_ABORT_EN
  assign w_abort = abort && (r_state != S_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  assign w_busy     = (r_state != S_IDLE);
  assign w_last     = (r_idx == IDX_W'(N_ENTRY - 1));
  assign w_skip     = (w_rd_data == '0);
  assign w_cnt_done = (r_cnt == CNT_W'(HOLD - 1));

  traffic_cfg_tbl #(
    .TIME_W   (TIME_W),
    .DEF_TIME (DEF_TIME)
  ) u_tbl (
    .clk     (clk),
    .rst     (rst),
    .i_busy  (w_busy),
    .i_we    (cfg_we),
    .i_waddr (cfg_addr),
    .i_wdata (cfg_time),
    .i_raddr (r_idx),
    .o_rdata (w_rd_data)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic; abort overrides every step decision
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (start) w_state_nxt = S_SCAN;
      S_SCAN:    if (!w_skip) w_state_nxt = S_SETUP;
                 else if (w_last) w_state_nxt = S_GO_WAIT;
      S_SETUP:   if (w_cnt_done) w_state_nxt = S_SEND;
      S_SEND:    w_state_nxt = w_last ? S_GO_WAIT : S_SCAN;
      S_GO_WAIT: if (w_cnt_done) w_state_nxt = S_GO;
      S_GO:      w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
    if (w_abort) w_state_nxt = S_IDLE;
  end

  // Outputs decoded from state; strobes are suppressed in an abort cycle
  always_comb begin
    inst_send = (r_state == S_SEND) && !w_abort;
    inst_go   = (r_state == S_GO)   && !w_abort;
    done      = (r_state == S_DONE) && !w_abort;
    busy      = w_busy;
    dbg_state = r_state;
  end

  // Datapath: index walk, mask capture, hold counter and field registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx         <= '0;
      r_mask        <= '0;
      r_cnt         <= '0;
      r_traffic_sel <= '0;
      r_color_sel   <= 1'b0;
      r_start_color <= 1'b0;
      r_input_time  <= '0;
    end else if (!w_abort) begin
      // Hold counter restarts whenever a wait state is entered
      if (((r_state == S_SETUP) || (r_state == S_GO_WAIT)) && (w_state_nxt == r_state))
        r_cnt <= r_cnt + 1'b1;
      else
        r_cnt <= '0;

      unique case (r_state)
        S_IDLE: if (start) begin
          r_mask <= start_mask;
          r_idx  <= '0;
        end
        S_SCAN: begin
          if (!w_skip) begin
            r_traffic_sel <= light_of(r_idx);
            r_color_sel   <= color_of(r_idx);
            r_start_color <= r_mask[light_of(r_idx)];
            r_input_time  <= w_rd_data;
          end else if (!w_last) begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_SEND: if (!w_last) r_idx <= r_idx + 1'b1;
        default: ;
      endcase
    end
  end

  assign traffic_sel = r_traffic_sel;
  assign color_sel   = r_color_sel;
  assign start_color = r_start_color;
  assign input_time  = r_input_time;

endmodule

// File: tb/tb_traffic_cfg_seq.sv
// Self-checking bench for traffic_cfg_seq. The reference model works from
// the table contents only: it computes the cycle of every send, the go and
// the done pulse with the pacing arithmetic, plus the fields each send carries.
module tb_traffic_cfg_seq;

  localparam int TIME_W   = 5;
  localparam int HOLD     = 2;
  localparam int DEF_TIME = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              start;
  logic [3:0]        start_mask;
  logic              cfg_we;
  logic [2:0]        cfg_addr;
  logic [TIME_W-1:0] cfg_time;
`ifdef TRAFFIC_CFG_ABORT_EN
  logic              abort;
`endif
  logic              inst_send;
  logic              inst_go;
  logic [1:0]        traffic_sel;
  logic              color_sel;
  logic              start_color;
  logic [TIME_W-1:0] input_time;
  logic              busy;
  logic              done;
  logic [2:0]        dbg_state;

  traffic_cfg_seq #(
    .TIME_W   (TIME_W),
    .HOLD     (HOLD),
    .DEF_TIME (DEF_TIME)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .start_mask  (start_mask),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_time    (cfg_time),
`ifdef TRAFFIC_CFG_ABORT_EN
    .abort       (abort),
`endif
    .inst_send   (inst_send),
    .inst_go     (inst_go),
    .traffic_sel (traffic_sel),
    .color_sel   (color_sel),
    .start_color (start_color),
    .input_time  (input_time),
    .busy        (busy),
    .done        (done),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [TIME_W-1:0] tbl_m [8];
  logic [8:0]        exp_q[$];      // {traffic_sel, color_sel, start_color, input_time}
  int                send_cyc_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wr(input logic [2:0] a, input logic [TIME_W-1:0] v);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_time = v;
    tbl_m[a] = v;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Start one replay and check every cycle until one cycle after done.
  task automatic run_seq(input logic [3:0] mask, input bit noise, input bit wr0,
                         input logic [2:0] wa, input logic [TIME_W-1:0] wv);
    int t;
    int go_c;
    int done_c;
    bit exp_send;
    logic [8:0] f;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    start = 1'b1; start_mask = mask;
    if (wr0) begin
      cfg_we = 1'b1; cfg_addr = wa; cfg_time = wv;
      tbl_m[wa] = wv;
    end
    exp_q.delete(); send_cyc_q.delete();
    t = 1;
    for (int k = 0; k < 8; k++) begin
      if (tbl_m[k] == 0) begin
        t += 1;
      end else begin
        f = {2'(k / 2), 1'(k % 2), mask[k / 2], tbl_m[k]};
        exp_q.push_back(f);
        send_cyc_q.push_back(t + HOLD + 1);
        t += HOLD + 2;
      end
    end
    go_c   = t + HOLD;
    done_c = go_c + 1;
    for (int c = 1; c <= done_c + 1; c++) begin
      @(negedge clk);
      start = 1'b0; cfg_we = 1'b0;
      exp_send = (send_cyc_q.size() > 0) && (send_cyc_q[0] == c);
      chk("busy", busy, (c <= done_c));
      chk("inst_send", inst_send, exp_send);
      chk("inst_go", inst_go, (c == go_c));
      chk("done", done, (c == done_c));
      if (exp_send) begin
        chk("fields", {traffic_sel, color_sel, start_color, input_time}, exp_q[0]);
        void'(exp_q.pop_front());
        void'(send_cyc_q.pop_front());
      end
      start_mask = 4'($urandom);
      if (noise && c <= done_c) begin
        if ($urandom_range(0, 2) == 0) start = 1'b1;
        if ($urandom_range(0, 2) == 0) begin
          cfg_we = 1'b1; cfg_addr = 3'($urandom); cfg_time = TIME_W'($urandom);
        end
      end
    end
    chk("sends_seen", send_cyc_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_go;
    int n_busy;
    rst = 1'b0; start = 1'b0; start_mask = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_time = '0;
`ifdef TRAFFIC_CFG_ABORT_EN
    abort = 1'b0;
`endif
    for (int i = 0; i < 8; i++) tbl_m[i] = TIME_W'(DEF_TIME);
    repeat (2) @(negedge clk);
    chk("rst_outs", {inst_send, inst_go, busy, done, traffic_sel, color_sel, start_color, input_time}, 0);
    rst = 1'b1;

    // defaults, mask 0
    run_seq(4'b0000, 0, 0, 0, 0);
    // table[3]=17, light 1 starts on the other colour
    wr(3'd3, 5'd17);
    run_seq(4'b0010, 0, 0, 0, 0);
    // everything skipped: go pulse still issued
    for (int i = 0; i < 8; i++) wr(3'(i), 5'd0);
    run_seq(4'b1111, 0, 0, 0, 0);
    // entries 0 and 5 zero
    for (int i = 0; i < 8; i++) wr(3'(i), (i == 0 || i == 5) ? 5'd0 : 5'(i + 3));
    run_seq(4'b0101, 0, 0, 0, 0);
    // mid-sequence start/cfg_we noise, then replay to read the table back
    run_seq(4'b1001, 1, 0, 0, 0);
    run_seq(4'b0110, 0, 0, 0, 0);
    // write and start in the same idle cycle: new value must be used
    run_seq(4'b0011, 0, 1, 3'd0, 5'd31);
    // randomized tables and masks
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++)
        wr(3'(i), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)));
      run_seq(4'($urandom), (r % 2) == 1, 0, 0, 0);
    end

    // reset at cycle 10 of a sequence
    @(negedge clk);
    start = 1'b1; start_mask = 4'hF;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b0;
    #1;
    chk("midrst_outs", {inst_send, inst_go, busy, done, traffic_sel, color_sel, start_color, input_time}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) tbl_m[i] = TIME_W'(DEF_TIME);
    n_go = 0; n_busy = 0;
    repeat (50) begin
      @(negedge clk);
      if (inst_go) n_go++;
      if (busy) n_busy++;
    end
    chk("midrst_no_go", n_go, 0);
    chk("midrst_no_busy", n_busy, 0);
    // table back at defaults after reset
    run_seq(4'b1010, 0, 0, 0, 0);

`ifdef TRAFFIC_CFG_ABORT_EN
    @(negedge clk);
    start = 1'b1; start_mask = 4'h3;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    abort = 1'b1;
    #1;
    chk("abort_strobes", {inst_send, inst_go, done}, 0);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    n_go = 0;
    repeat (40) begin
      @(negedge clk);
      if (inst_go || done || busy) n_go++;
    end
    chk("abort_quiet", n_go, 0);
    run_seq(4'b0001, 0, 0, 0, 0);
`endif

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
